// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, requests words from instruction memory with a busywait handshake,
// and holds each fetched word for one execute phase before computing the next PC.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_INSTR,
  input  logic        STALL,
  input  logic        JUMP,
  input  logic        BRANCH_TAKEN,
  input  logic [7:0]  OFFSET,
  output logic        IMEM_READ,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        INSTR_VALID,
  output logic [15:0] FETCH_COUNT
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StExec
  } state_e;

  state_e      state_q;
  logic [31:0] seq_pc;
  logic [31:0] rel_off;
  logic [31:0] next_pc;

  // OFFSET counts words: sign-extend from bit 7, then scale to bytes.
  always_comb begin
    seq_pc  = PC + 32'(PC_STEP);
    rel_off = {{22{OFFSET[7]}}, OFFSET, 2'b00};
    next_pc = (JUMP || BRANCH_TAKEN) ? seq_pc + rel_off : seq_pc;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      PC          <= RESET_PC;
      INSTRUCTION <= 32'h0;
      INSTR_VALID <= 1'b0;
      IMEM_READ   <= 1'b0;
      FETCH_COUNT <= 16'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q   <= StReq;
          IMEM_READ <= 1'b1;
        end
        StReq: begin
          if (!IMEM_BUSYWAIT) begin
            state_q     <= StExec;
            INSTRUCTION <= IMEM_INSTR;
            INSTR_VALID <= 1'b1;
            IMEM_READ   <= 1'b0;
            FETCH_COUNT <= FETCH_COUNT + 16'd1;
          end
        end
        StExec: begin
          if (!STALL) begin
            state_q     <= StReq;
            PC          <= next_pc;
            INSTR_VALID <= 1'b0;
            IMEM_READ   <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          INSTR_VALID <= 1'b0;
          IMEM_READ   <= 1'b0;
        end
      endcase
    end
  end

endmodule
